// File: rtl/apple2_paddle_timer.sv
// Apple II game-port paddle timers: per-channel one-shots retriggered by the
// paddle strobe, timed in CLK_2M rising-edge ticks sampled on CLK_14M.
module apple2_paddle_timer #(
    parameter int NUM_PDL   = 4,
    parameter int CNT_W     = 13,
    parameter int CENTER    = 2800,
    parameter int GAIN      = 22,
    parameter int CLAMP_TH  = 5590,
    parameter int MAX_COUNT = 5650
) (
    input  logic                 CLK_14M,
    input  logic                 reset,
    input  logic                 CLK_2M,
    input  logic                 pdl_strobe,
    input  logic [8*NUM_PDL-1:0] joy_an,
    input  logic [NUM_PDL-1:0]   an_unsigned,
    output logic [NUM_PDL-1:0]   pdl
);

    localparam int LW = CNT_W + 3;
    localparam logic signed [LW-1:0] CENTER_S = LW'(CENTER);
    localparam logic signed [LW-1:0] GAIN_S   = LW'(GAIN);
    localparam logic signed [LW-1:0] CLAMP_S  = LW'(CLAMP_TH);
    localparam logic [CNT_W-1:0]     MAX_C    = CNT_W'(MAX_COUNT);

    logic                    clk2m_d;
    logic                    tick;
    logic        [CNT_W-1:0] cnt  [NUM_PDL];
    logic        [CNT_W-1:0] load [NUM_PDL];
    logic signed [LW-1:0]    raw  [NUM_PDL];

    assign tick = CLK_2M & ~clk2m_d;

    always_comb begin
        for (int i = 0; i < NUM_PDL; i++) begin
            raw[i]  = '0;
            load[i] = '0;
            if (an_unsigned[i])
                raw[i] = GAIN_S * $signed({{(LW-8){1'b0}}, joy_an[8*i +: 8]});
            else
                raw[i] = CENTER_S + GAIN_S * $signed({{(LW-8){joy_an[8*i+7]}}, joy_an[8*i +: 8]});
            if (raw[i] < 0)
                load[i] = '0;
            else if (raw[i] >= CLAMP_S)
                load[i] = MAX_C;
            else
                load[i] = raw[i][CNT_W-1:0];
        end
    end

    // clk2m_d resets high so a CLK_2M already high at release is not a tick
    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            clk2m_d <= 1'b1;
            pdl     <= '0;
            for (int i = 0; i < NUM_PDL; i++)
                cnt[i] <= '0;
        end else begin
            clk2m_d <= CLK_2M;
            if (tick) begin
                for (int i = 0; i < NUM_PDL; i++) begin
                    pdl[i] <= (cnt[i] != '0);
                    if (pdl_strobe)
                        cnt[i] <= load[i];
                    else if (cnt[i] != '0)
                        cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_apple2_paddle_timer.sv
// Directed bench for apple2_paddle_timer: measures pulse widths in ticks for
// all four channels against hand-computed loads.
module tb_apple2_paddle_timer;

    logic        CLK_14M = 1'b0;
    logic        reset;
    logic        CLK_2M;
    logic        pdl_strobe;
    logic [31:0] joy_an;
    logic [3:0]  an_unsigned;
    logic [3:0]  pdl;

    int n_checks = 0;
    int n_errors = 0;
    int hi_cnt   [4];
    int first_hi [4];
    int last_hi  [4];

    apple2_paddle_timer dut (
        .CLK_14M     (CLK_14M),
        .reset       (reset),
        .CLK_2M      (CLK_2M),
        .pdl_strobe  (pdl_strobe),
        .joy_an      (joy_an),
        .an_unsigned (an_unsigned),
        .pdl         (pdl)
    );

    always #5 CLK_14M = ~CLK_14M;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one CLK_2M rising edge; returns at the negedge after the tick posedge
    task automatic do_tick;
        @(negedge CLK_14M) CLK_2M = 1'b1;
        @(negedge CLK_14M) CLK_2M = 1'b0;
    endtask

    task automatic sample_pdl(input int k);
        for (int i = 0; i < 4; i++) begin
            if (pdl[i]) begin
                hi_cnt[i]++;
                if (first_hi[i] == 0) first_hi[i] = k;
                last_hi[i] = k;
            end
        end
    endtask

    // strobe tick T0, then n ticks; strobe also held for ticks 1..hold and
    // optionally at alt_at, where joy_an switches to alt_joy
    task automatic run_pulse(input logic [31:0] joy, input logic [3:0] mode, input int n,
                             input int hold, input int alt_at, input logic [31:0] alt_joy,
                             input logic alt_strobe);
        joy_an      = joy;
        an_unsigned = mode;
        pdl_strobe  = 1'b1;
        do_tick;
        pdl_strobe  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hi_cnt[i] = 0; first_hi[i] = 0; last_hi[i] = 0;
        end
        for (int k = 1; k <= n; k++) begin
            if (k == alt_at) joy_an = alt_joy;
            pdl_strobe = (k <= hold) || (k == alt_at && alt_strobe);
            do_tick;
            pdl_strobe = 1'b0;
            sample_pdl(k);
        end
    endtask

    task automatic check_widths(input string name, input int e0, input int e1,
                                input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s ch%0d high ticks", name, i), hi_cnt[i], e[i]);
            check_val($sformatf("%s ch%0d first tick", name, i), first_hi[i], (e[i] > 0) ? 1 : 0);
            check_val($sformatf("%s ch%0d last tick", name, i), last_hi[i], e[i]);
        end
    endtask

    initial begin
        reset       = 1'b1;
        CLK_2M      = 1'b0;
        pdl_strobe  = 1'b0;
        joy_an      = '0;
        an_unsigned = '0;

        // reset with CLK_2M toggling, release with CLK_2M high and strobe up
        repeat (3) @(negedge CLK_14M) CLK_2M = ~CLK_2M;
        check_val("reset pdl", int'(pdl), 0);
        @(negedge CLK_14M) begin CLK_2M = 1'b1; pdl_strobe = 1'b1; end
        @(negedge CLK_14M) reset = 1'b0;
        @(negedge CLK_14M);
        check_val("release first cycle pdl", int'(pdl), 0);
        pdl_strobe = 1'b0;
        CLK_2M     = 1'b0;
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        for (int k = 1; k <= 5; k++) begin
            do_tick;
            sample_pdl(k);
        end
        check_val("no spurious tick at release", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

        // ch0 signed 0x00, ch1 signed 0x80, ch2 signed 0x7F, ch3 unsigned 0xFF
        run_pulse({8'hFF, 8'h7F, 8'h80, 8'h00}, 4'b1000, 5700, 0, 0, '0, 1'b0);
        check_widths("clampA", 2800, 0, 5650, 5650);

        // ch0 signed 0x7E, ch1 unsigned 0x64, ch2 unsigned 0x00, ch3 signed 0x00;
        // joy_an changes at tick 100 without a strobe
        run_pulse({8'h00, 8'h00, 8'h64, 8'h7E}, 4'b0110, 5650, 0, 100,
                  {8'h7F, 8'h7F, 8'hFF, 8'h80}, 1'b0);
        check_widths("midchg", 5572, 2200, 0, 2800);

        // retrigger at tick 1000; ch3 reloads 0 but still shows the old count on that tick
        run_pulse(32'h0, 4'b0000, 6700, 0, 1000, {8'h80, 8'h00, 8'h7E, 8'h7F}, 1'b1);
        check_widths("retrig", 6650, 6572, 3800, 1000);

        // strobe held for three ticks, ch3 unsigned 0x01 -> 22
        run_pulse({8'h01, 8'h00, 8'h00, 8'h00}, 4'b1111, 40, 2, 0, '0, 1'b0);
        check_widths("held", 0, 0, 0, 24);

        // reset mid-pulse at tick 500
        run_pulse(32'h0, 4'b0000, 500, 0, 0, '0, 1'b0);
        check_val("pre-reset ch0 high ticks", hi_cnt[0], 500);
        @(negedge CLK_14M) reset = 1'b1;
        @(negedge CLK_14M);
        check_val("mid-pulse reset pdl", int'(pdl), 0);
        reset = 1'b0;
        // strobe with no tick inside is ignored
        @(negedge CLK_14M) pdl_strobe = 1'b1;
        @(negedge CLK_14M) pdl_strobe = 1'b0;
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        for (int k = 1; k <= 3000; k++) begin
            do_tick;
            sample_pdl(k);
        end
        check_val("after reset stays low", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
